// File: rtl/mprj_io_cfg_bank.sv
// Wishbone-mapped bank of user IO pad config registers plus a power-control register and a serial shifter.
// Optional feature: define MPRJ_CFG_XFER_IRQ_EN to add a sticky transfer-done flag (XFER bit1) and xfer_irq.
module mprj_io_cfg_bank #(
  parameter int unsigned NUM_PADS = 38,
  parameter int unsigned CFG_BITS = 13,
  parameter int unsigned PWR_BITS = 4,
  parameter logic [31:0] BASE_ADR = 32'h2600_0000,
  parameter logic [31:0] INIT_CFG = 32'h0000_0403
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wb_stb_i,
  input  logic                wb_cyc_i,
  input  logic                wb_we_i,
  input  logic [3:0]          wb_sel_i,
  input  logic [31:0]         wb_adr_i,
  input  logic [31:0]         wb_dat_i,
  output logic                wb_ack_o,
  output logic [31:0]         wb_dat_o,
  output logic [PWR_BITS-1:0] pwr_ctrl_out,
  output logic                serial_clock,
  output logic                serial_data_out,
  output logic                serial_load,
`ifdef MPRJ_CFG_XFER_IRQ_EN
  output logic                xfer_irq,
`endif
  output logic                serial_busy
);

  localparam int unsigned TOTAL  = NUM_PADS * CFG_BITS;
  localparam int unsigned CNT_W  = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int unsigned PAD_W0 = 9;
  localparam logic [CFG_BITS-1:0] INIT_V = CFG_BITS'(INIT_CFG);

  typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LOAD, DONE} state_t;

  state_t             state_q, state_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic [CFG_BITS-1:0] pad_cfg [NUM_PADS];
  logic [PWR_BITS-1:0] pwr_q;
  logic [TOTAL-1:0]   flat;
  logic [31:0]        word_idx;
  logic [31:0]        rdata;
  logic               hit, wr, xfer_sel, pwr_sel, pad_wr, start, done_bit;
  logic               unused_adr;

  assign unused_adr   = ^wb_adr_i[1:0];
  assign pwr_ctrl_out = pwr_q;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Address decode; the !ack term guarantees a dead cycle between acks.
  always_comb begin
    hit      = wb_stb_i & wb_cyc_i & (wb_adr_i[31:8] == BASE_ADR[31:8]) & ~wb_ack_o;
    wr       = hit & wb_we_i;
    word_idx = 32'(wb_adr_i[7:2]);
    xfer_sel = (word_idx == 32'd0);
    pwr_sel  = (word_idx == 32'd1);
    pad_wr   = wr & (state_q == IDLE);
    start    = wr & xfer_sel & wb_sel_i[0] & wb_dat_i[0] & (state_q == IDLE);
  end

  always_comb begin
    rdata = '0;
    if (xfer_sel) rdata = {30'd0, done_bit, (state_q != IDLE)};
    else if (pwr_sel) rdata = 32'(pwr_q);
    for (int unsigned i = 0; i < NUM_PADS; i++)
      if (word_idx == 32'(PAD_W0 + i)) rdata = 32'(pad_cfg[i]);
  end

  // Register file and Wishbone response; pad writes are dropped while shifting.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      pwr_q    <= '0;
      for (int unsigned i = 0; i < NUM_PADS; i++) pad_cfg[i] <= INIT_V;
    end else begin
      wb_ack_o <= hit;
      wb_dat_o <= hit ? rdata : '0;
      if (wr && pwr_sel) pwr_q <= PWR_BITS'(merge(32'(pwr_q), wb_dat_i, wb_sel_i));
      for (int unsigned i = 0; i < NUM_PADS; i++)
        if (pad_wr && word_idx == 32'(PAD_W0 + i))
          pad_cfg[i] <= CFG_BITS'(merge(32'(pad_cfg[i]), wb_dat_i, wb_sel_i));
    end
  end

`ifdef MPRJ_CFG_XFER_IRQ_EN
  logic done_q;
  assign done_bit = done_q;
  assign xfer_irq = done_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) done_q <= 1'b0;
    else if (state_q == LOAD) done_q <= 1'b1;
    else if (wr && xfer_sel && wb_sel_i[0] && wb_dat_i[1]) done_q <= 1'b0;
  end
`else
  assign done_bit = 1'b0;
`endif

  // Pad N-1 occupies the top of the flat vector so counting down yields the required bit order.
  always_comb begin
    flat = '0;
    for (int unsigned i = 0; i < NUM_PADS; i++) flat[i*CFG_BITS +: CFG_BITS] = pad_cfg[i];
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    case (state_q)
      IDLE: if (start) begin
        state_nxt = SHIFT_LO;
        cnt_nxt   = CNT_W'(TOTAL - 1);
      end
      SHIFT_LO: state_nxt = SHIFT_HI;
      SHIFT_HI: begin
        if (cnt_q == '0) state_nxt = LOAD;
        else begin
          state_nxt = SHIFT_LO;
          cnt_nxt   = cnt_q - CNT_W'(1);
        end
      end
      LOAD:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Serial outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      serial_clock    <= 1'b0;
      serial_data_out <= 1'b0;
      serial_load     <= 1'b0;
      serial_busy     <= 1'b0;
    end else begin
      serial_clock <= (state_nxt == SHIFT_HI);
      serial_load  <= (state_nxt == LOAD);
      serial_busy  <= (state_nxt != IDLE);
      if (state_nxt == SHIFT_LO) serial_data_out <= flat[cnt_nxt];
      else if (state_nxt != SHIFT_HI) serial_data_out <= 1'b0;
    end
  end

endmodule

// File: doc/mprj_io_cfg_bank.md
MPRJ_IO_CFG_BANK -- requirements
Module: mprj_io_cfg_bank

Interface
REQ-001 SHALL have parameter NUM_PADS, default 38; number of user IO pad config registers (1..64).
REQ-002 SHALL have parameter CFG_BITS, default 13; config bits per pad (1..32).
REQ-003 SHALL have parameter PWR_BITS, default 4; power-control register width (1..32).
REQ-004 SHALL have parameter BASE_ADR, default 32'h2600_0000; block base address, 256-byte aligned.
REQ-005 SHALL have parameter INIT_CFG, default 13'h0403; pad config reset value, truncated or zero-extended to CFG_BITS.
REQ-006 SHALL have ports wb_clk_i in 1 (sole clock) and wb_rst_i in 1; one clock, reset synchronous and active-high.
REQ-007 SHALL have Wishbone slave ports wb_stb_i in 1, wb_cyc_i in 1, wb_we_i in 1, wb_sel_i in 4, wb_adr_i in 32, wb_dat_i in 32, wb_ack_o out 1, wb_dat_o out 32.
REQ-008 SHALL have outputs pwr_ctrl_out out PWR_BITS, serial_clock out 1, serial_data_out out 1, serial_load out 1, serial_busy out 1.

Function
REQ-009 Register map (offset from BASE_ADR) SHALL be: 0x00 XFER (bit0 W1 start, bit0 R busy), 0x04 PWR, 0x24+4*i pad i config for i in 0..NUM_PADS-1.
REQ-010 Hit SHALL be wb_stb_i & wb_cyc_i & wb_adr_i[31:8]==BASE_ADR[31:8] & wb_ack_o==0; non-hits SHALL never ack.
REQ-011 wb_ack_o SHALL assert exactly one cycle, on the cycle after a hit, then deassert for at least one cycle.
REQ-012 wb_dat_o SHALL be valid while wb_ack_o is high; reads of unmapped offsets SHALL ack with 0; unused upper bits SHALL read 0.
REQ-013 Writes SHALL update only bytes with wb_sel_i set; writes to unmapped offsets SHALL be acked and discarded.
REQ-014 Register update SHALL take effect on the same edge that raises wb_ack_o; pwr_ctrl_out SHALL mirror PWR directly.
REQ-015 Serial FSM states SHALL be IDLE, SHIFT_LO, SHIFT_HI, LOAD, DONE.
REQ-016 IDLE->SHIFT_LO SHALL occur on a write to XFER with wb_dat_i[0]=1 and wb_sel_i[0]=1; bit counter SHALL load NUM_PADS*CFG_BITS-1.
REQ-017 SHIFT_LO SHALL drive serial_clock=0 and serial_data_out=current bit; SHIFT_HI SHALL drive serial_clock=1 with data held; one bit SHALL take 2 cycles.
REQ-018 Bit order SHALL be pad NUM_PADS-1 first, MSB first within each pad, ending with pad 0 bit 0.
REQ-019 After the SHIFT_HI of the last bit the FSM SHALL enter LOAD (serial_load=1 for 1 cycle), then DONE (1 cycle), then IDLE.
REQ-020 serial_busy and XFER bit0 read SHALL be 1 in every state except IDLE.
REQ-021 Start writes while busy SHALL be acked and ignored, with no restart.
REQ-022 Pad config writes while busy SHALL be acked and discarded so shifted data stays consistent; PWR writes while busy SHALL take effect.
REQ-023 Total transfer SHALL be 2*NUM_PADS*CFG_BITS+2 cycles from start-write ack edge to return to IDLE.

Reset
REQ-024 While wb_rst_i is high at a clock edge: pad configs SHALL be INIT_CFG, PWR SHALL be 0, FSM SHALL be IDLE, wb_ack_o, serial_clock, serial_data_out, serial_load and serial_busy SHALL be 0, and wb_dat_o SHALL be 0.
REQ-025 Reset mid-transfer SHALL abort at once with no serial_load pulse; reset during an ack cycle SHALL drop wb_ack_o on that edge.

Configuration
REQ-026 With macro MPRJ_CFG_XFER_IRQ_EN defined, the block SHALL add output xfer_irq (1 bit) and XFER bit1 (R sticky done flag, W1 clears); the flag SHALL set on entry to DONE, xfer_irq SHALL equal the flag, and reset SHALL clear it.
REQ-027 Without MPRJ_CFG_XFER_IRQ_EN the xfer_irq port SHALL be absent and XFER bit1 SHALL read 0.

Verification
REQ-028 Reset, then read each pad register -> each reads 32'h0403; PWR reads 0; ack width exactly 1 cycle.
REQ-029 Write random 7-bit value to each pad 0x24+4*i, then read back -> exact match; write 0xA to 0x04 -> pwr_ctrl_out=4'hA.
REQ-030 Write pad 0 with wb_sel_i=4'b0010, data 32'hFFFF_FFFF -> reads 32'h1F03 (CFG_BITS=13).
REQ-031 Pad 37=13'h1555, others 0, start transfer -> first 13 serial_data_out bits sampled on serial_clock rise are 1,0,1,0,...,1; serial_load pulses once after 494 rises; busy clears 990 cycles after start.
REQ-032 Mid-transfer: write pad 5 and a second start -> both acked, pad 5 unchanged, no restart; assert wb_rst_i at bit 100 -> busy=0 next edge, no serial_load.
REQ-033 With MPRJ_CFG_XFER_IRQ_EN: transfer completes -> xfer_irq=1 and XFER reads 32'h2; write 32'h2 to XFER -> xfer_irq=0.
